prio_grant_ctrl: RTL and testbench

- Downstream consumer of the 4-input registered priority encoder.
- Takes the encoder's channel index (Y) and valid, and issues a one-hot grant to the selected requester.
- Holds the grant until the requester signals done, or until a timeout expires.
- Keeps per-channel service counts. Sits between the encoder and the four requester ports.

---
 rtl/prio_grant_pkg.sv | 20 ++
 rtl/grant_timer.sv | 31 +++
 rtl/prio_grant_ctrl.sv | 119 +++++++++++
 tb/tb_prio_grant_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prio_grant_pkg.sv
// Shared types and helpers for the priority grant controller.
package prio_grant_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_e;

    function automatic logic [NUM_CH-1:0] onehot(input logic [CH_W-1:0] idx);
        logic [NUM_CH-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/grant_timer.sv
// Grant hold timer: clears to 0, counts while enabled, flags TIMEOUT_CYC-1.
module grant_timer #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign tc = (cnt_q == 8'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/prio_grant_ctrl.sv
// One-hot grant controller behind the priority encoder, with timeout release.
// Define PRIO_SVC_CNT_EN to build the per-channel saturating service counters.
module prio_grant_ctrl
    import prio_grant_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CH_W-1:0]         Y,
    input  logic                    valid,
    input  logic                    done,
    input  logic                    clr_err,
    output logic [NUM_CH-1:0]       gnt,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    err_sticky,
    output logic [NUM_CH*CNT_W-1:0] svc_cnt
);

    state_e            state_q, state_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              busy_q, busy_d;
    logic              tout_q, tout_d;
    logic              err_q, err_d;
    logic              tc, svc_done, tout_evt;

    grant_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (state_q != GRANT),
        .en  (state_q == GRANT),
        .tc  (tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ch_q    <= '0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            tout_q  <= tout_d;
            err_q   <= err_d;
        end
    end

    // done has priority over the timer's terminal count
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        svc_done = 1'b0;
        tout_evt = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid) begin
                    ch_d    = Y;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    svc_done = 1'b1;
                    state_d  = RELEASE;
                end else if (tc) begin
                    tout_evt = 1'b1;
                    state_d  = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are computed from the next state so they register with no extra lag
    always_comb begin
        gnt_d  = (state_d == GRANT) ? onehot(ch_d) : '0;
        busy_d = (state_d != IDLE);
        tout_d = tout_evt;
        err_d  = tout_evt | (err_q & ~clr_err);
    end

    assign gnt         = gnt_q;
    assign busy        = busy_q;
    assign timeout_err = tout_q;
    assign err_sticky  = err_q;

`ifdef PRIO_SVC_CNT_EN
    logic [NUM_CH-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (svc_done && (cnt_q[ch_q] != '1))
            cnt_d[ch_q] = cnt_q[ch_q] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign svc_cnt = cnt_q;
`else
    logic unused_svc_done;
    assign unused_svc_done = svc_done;
    assign svc_cnt         = '0;
`endif

endmodule

// File: tb/tb_prio_grant_ctrl.sv
// Scoreboard bench for prio_grant_ctrl; expectations follow PRIO_SVC_CNT_EN.
module tb_prio_grant_ctrl;

    localparam int TO = 16;
    localparam int CW = 8;
`ifdef PRIO_SVC_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    Y = '0;
    logic          valid = 1'b0;
    logic          done = 1'b0;
    logic          clr_err = 1'b0;
    logic [3:0]    gnt;
    logic          busy, timeout_err, err_sticky;
    logic [4*CW-1:0] svc_cnt;

    int total = 0;
    int bad   = 0;
    logic [3:0] exp_q[$];
    int cnt_exp[4] = '{0, 0, 0, 0};
    logic [3:0] e;

    prio_grant_ctrl #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Y(Y), .valid(valid), .done(done), .clr_err(clr_err),
        .gnt(gnt), .busy(busy), .timeout_err(timeout_err), .err_sticky(err_sticky),
        .svc_cnt(svc_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [CW-1:0] exp_cnt(input int ch);
        return CNT_EN ? CW'(cnt_exp[ch]) : '0;
    endfunction

    function automatic logic [3:0] oh(input logic [1:0] y);
        logic [3:0] v;
        v = 4'b0001;
        return v << y;
    endfunction

    // Bookkeeping for a completed service in the reference model
    task automatic served(input int ch);
        if (cnt_exp[ch] < (1 << CW) - 1) cnt_exp[ch]++;
    endtask

    // Present one request at a negedge; returns at the negedge of the first GRANT cycle
    task automatic issue(input logic [1:0] y);
        valid = 1'b1;
        Y     = y;
        exp_q.push_back(oh(y));
        @(negedge clk);
        valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (rst && gnt != 4'b0) begin
            total++;
            if (!busy || !$onehot(gnt)) begin
                bad++;
                $display("FAIL gnt_invariant gnt=%b busy=%b", gnt, busy);
            end
        end
    end

    task automatic test_reset;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, busy, timeout_err, err_sticky} !== 7'b0 || svc_cnt !== '0) begin
            bad++;
            $display("FAIL reset_state gnt=%b busy=%b to=%b err=%b cnt=%h want all 0",
                     gnt, busy, timeout_err, err_sticky, svc_cnt);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_release busy=%b want 0", busy);
        end
    endtask

    task automatic test_basic;
        issue(2'd3);
        for (int c = 1; c <= 3; c++) begin
            if (c == 1) begin
                e = exp_q.pop_front();
            end
            total++;
            if (gnt !== e || busy !== 1'b1) begin
                bad++;
                $display("FAIL basic_gnt c=%0d gnt=%b busy=%b want %b/1", c, gnt, busy, e);
            end
            if (c == 3) done = 1'b1;
            @(negedge clk);
        end
        done = 1'b0;
        served(3);
        total++;
        if (gnt !== 4'b0 || busy !== 1'b1 || timeout_err !== 1'b0 || svc_cnt[3*CW +: CW] !== exp_cnt(3)) begin
            bad++;
            $display("FAIL basic_release gnt=%b busy=%b to=%b cnt3=%0d want 0/1/0/%0d",
                     gnt, busy, timeout_err, svc_cnt[3*CW +: CW], exp_cnt(3));
        end
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL basic_idle busy=%b gnt=%b want 0/0", busy, gnt);
        end
    endtask

    task automatic test_timeout;
        for (int r = 0; r < 2; r++) begin
            issue(2'd1);
            e = exp_q.pop_front();
            for (int c = 1; c <= TO; c++) begin
                total++;
                if (gnt !== e || timeout_err !== 1'b0) begin
                    bad++;
                    $display("FAIL timeout_hold r=%0d c=%0d gnt=%b to=%b want %b/0", r, c, gnt, timeout_err, e);
                end
                // second round: clear collides with the timeout event
                if (r == 1 && c == TO) clr_err = 1'b1;
                @(negedge clk);
            end
            clr_err = 1'b0;
            total++;
            if (gnt !== 4'b0 || busy !== 1'b1 || timeout_err !== 1'b1 || err_sticky !== 1'b1 ||
                svc_cnt[1*CW +: CW] !== exp_cnt(1)) begin
                bad++;
                $display("FAIL timeout_fire r=%0d gnt=%b busy=%b to=%b err=%b cnt1=%0d want 0/1/1/1/%0d",
                         r, gnt, busy, timeout_err, err_sticky, svc_cnt[1*CW +: CW], exp_cnt(1));
            end
            @(negedge clk);
            total++;
            if (timeout_err !== 1'b0 || err_sticky !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL timeout_after to=%b err=%b busy=%b want 0/1/0", timeout_err, err_sticky, busy);
            end
            clr_err = 1'b1;
            @(negedge clk);
            clr_err = 1'b0;
            total++;
            if (err_sticky !== 1'b0) begin
                bad++;
                $display("FAIL clr_err err=%b want 0", err_sticky);
            end
        end
    endtask

    task automatic test_tie;
        issue(2'd0);
        e = exp_q.pop_front();
        for (int c = 1; c <= TO; c++) begin
            total++;
            if (gnt !== e) begin
                bad++;
                $display("FAIL tie_hold c=%0d gnt=%b want %b", c, gnt, e);
            end
            if (c == TO) done = 1'b1;
            @(negedge clk);
        end
        done = 1'b0;
        served(0);
        total++;
        if (timeout_err !== 1'b0 || err_sticky !== 1'b0 || busy !== 1'b1 || svc_cnt[0 +: CW] !== exp_cnt(0)) begin
            bad++;
            $display("FAIL tie_release to=%b err=%b busy=%b cnt0=%0d want 0/0/1/%0d",
                     timeout_err, err_sticky, busy, svc_cnt[0 +: CW], exp_cnt(0));
        end
        @(negedge clk);
    endtask

    task automatic test_ignored;
        issue(2'd2);
        e = exp_q.pop_front();
        for (int c = 1; c <= 5; c++) begin
            total++;
            if (gnt !== e) begin
                bad++;
                $display("FAIL ignored_gnt c=%0d gnt=%b want %b", c, gnt, e);
            end
            valid = ~valid;
            Y     = 2'd0;
            if (c == 5) done = 1'b1;
            @(negedge clk);
        end
        done  = 1'b0;
        valid = 1'b1;
        served(2);
        @(negedge clk);
        valid = 1'b0;
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0 || svc_cnt[2*CW +: CW] !== exp_cnt(2)) begin
            bad++;
            $display("FAIL ignored_release_valid busy=%b gnt=%b cnt2=%0d want 0/0/%0d",
                     busy, gnt, svc_cnt[2*CW +: CW], exp_cnt(2));
        end
        done = 1'b1;
        repeat (3) @(negedge clk);
        done = 1'b0;
        total++;
        if (busy !== 1'b0 || svc_cnt !== {exp_cnt(3), exp_cnt(2), exp_cnt(1), exp_cnt(0)}) begin
            bad++;
            $display("FAIL idle_done busy=%b cnt=%h want 0/%h", busy, svc_cnt,
                     {exp_cnt(3), exp_cnt(2), exp_cnt(1), exp_cnt(0)});
        end
    endtask

    task automatic test_async_reset;
        issue(2'd2);
        e = exp_q.pop_front();
        total++;
        if (gnt !== e) begin
            bad++;
            $display("FAIL areset_pre gnt=%b want %b", gnt, e);
        end
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) cnt_exp[i] = 0;
        total++;
        if (gnt !== 4'b0 || busy !== 1'b0 || err_sticky !== 1'b0 || svc_cnt !== '0) begin
            bad++;
            $display("FAIL areset_now gnt=%b busy=%b err=%b cnt=%h want 0", gnt, busy, err_sticky, svc_cnt);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt !== 4'b0) begin
            bad++;
            $display("FAIL areset_idle busy=%b gnt=%b want 0/0", busy, gnt);
        end
        issue(2'd1);
        e = exp_q.pop_front();
        total++;
        if (gnt !== e) begin
            bad++;
            $display("FAIL areset_regrant gnt=%b want %b", gnt, e);
        end
        done = 1'b1;
        @(negedge clk);
        done = 1'b0;
        served(1);
        @(negedge clk);
    endtask

    task automatic test_saturation;
        for (int n = 0; n < 260; n++) begin
            issue(2'd0);
            e = exp_q.pop_front();
            total++;
            if (gnt !== e) begin
                bad++;
                $display("FAIL sat_gnt n=%0d gnt=%b want %b", n, gnt, e);
            end
            done = 1'b1;
            @(negedge clk);
            done = 1'b0;
            served(0);
            @(negedge clk);
        end
        total++;
        if (svc_cnt[0 +: CW] !== exp_cnt(0) || svc_cnt[1*CW +: CW] !== exp_cnt(1)) begin
            bad++;
            $display("FAIL saturation cnt0=%0d cnt1=%0d want %0d/%0d",
                     svc_cnt[0 +: CW], svc_cnt[1*CW +: CW], exp_cnt(0), exp_cnt(1));
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_timeout;
        test_tie;
        test_ignored;
        test_async_reset;
        test_saturation;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
